// File: rtl/mipi_csi2_pkt_unpack_pkg.sv
// Shared constants for the CSI-2 2-lane packet unpacker: data types, FSM encoding, CRC constants.
package mipi_csi2_pkt_unpack_pkg;

  localparam logic [7:0] DT_FS       = 8'h00;
  localparam logic [7:0] DT_FE       = 8'h01;
  localparam logic [7:0] DT_LS       = 8'h02;
  localparam logic [7:0] DT_LE       = 8'h03;
  localparam logic [7:0] DT_YUV422_8 = 8'h1E;
  localparam logic [7:0] DT_RGB565   = 8'h22;
  localparam logic [7:0] DT_RAW10    = 8'h2B;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_HDR2     = 3'd1;
  localparam logic [2:0] ST_PAYLOAD  = 3'd2;
  localparam logic [2:0] ST_CRC      = 3'd3;
  localparam logic [2:0] ST_WAIT_EOT = 3'd4;

  // CRC-16/CCITT in reflected form, processed LSB-first
  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'h8408;

endpackage

// File: rtl/mipi_csi2_pkt_unpack_if.sv
// Byte-stream input and unpacked pixel-stream output of the CSI-2 unpacker.
interface mipi_csi2_pkt_unpack_if;

  logic [15:0] I_Byte_Data;
  logic        I_Byte_Valid;
  logic [15:0] O_Mipi_Unpacket_Data;
  logic        O_Mipi_Unpacket_Vaild;
  logic        O_Mipi_Unpacket_V_sync;
  logic [15:0] O_Line_Cnt;
  logic        O_Pkt_Err;
  logic        O_Crc_Err;

  modport master (
    output I_Byte_Data, I_Byte_Valid,
    input  O_Mipi_Unpacket_Data, O_Mipi_Unpacket_Vaild, O_Mipi_Unpacket_V_sync,
    input  O_Line_Cnt, O_Pkt_Err, O_Crc_Err
  );

  modport slave (
    input  I_Byte_Data, I_Byte_Valid,
    output O_Mipi_Unpacket_Data, O_Mipi_Unpacket_Vaild, O_Mipi_Unpacket_V_sync,
    output O_Line_Cnt, O_Pkt_Err, O_Crc_Err
  );

endinterface

// File: rtl/mipi_crc16_2byte.sv
// Two-bytes-per-cycle CSI-2 payload CRC accumulator; only built when MIPI_CRC_CHECK_EN is defined.
`ifdef MIPI_CRC_CHECK_EN
module mipi_crc16_2byte
  import mipi_csi2_pkt_unpack_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] din,
  output logic [15:0] crc
);

  function automatic logic [15:0] crc_byte(input logic [15:0] c_in, input logic [7:0] b);
    logic [15:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      c = (c >> 1) ^ (((c[0] ^ b[i]) == 1'b1) ? CRC_POLY : 16'h0000);
    end
    return c;
  endfunction

  logic [15:0] crc_nxt;

  // Lane 0 carries the earlier byte, so it enters the CRC first
  always_comb begin
    crc_nxt = crc_byte(crc_byte(crc, din[7:0]), din[15:8]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= CRC_INIT;
    end else if (clr) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc_nxt;
    end
  end

endmodule
`endif

// File: rtl/mipi_csi2_pkt_unpack.sv
// CSI-2 2-lane packet unpacker: FS/FE to V_sync, accepted long packets to a 16-bit word stream.
// Optional payload CRC check is enabled with the MIPI_CRC_CHECK_EN macro.
module mipi_csi2_pkt_unpack
  import mipi_csi2_pkt_unpack_pkg::*;
#(
  parameter int         Lane_Num   = 2,
  parameter int         Byte_w     = 8,
  parameter logic [7:0] DT_Accept  = DT_YUV422_8,
  parameter logic [1:0] VC_Accept  = 2'd0,
  parameter int         Line_Bytes = 3840
) (
  input logic                   I_CLK,
  input logic                   I_Rst_n,
  mipi_csi2_pkt_unpack_if.slave bus
);

  localparam int WORD_W = Lane_Num * Byte_w;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [2:0]        state;
  logic [7:0]        di;
  logic [7:0]        wc_lo;
  logic [14:0]       word_cnt;
  logic              fwd;
  logic              err_done;
  logic [WORD_W-1:0] data_p1;
  logic              vld_p1;
  logic              vsync;
  logic [15:0]       line_cnt;
  logic              pkt_err;

  logic [WORD_W-1:0] in_data;
  logic              in_vld;
  logic [15:0]       wc;
  logic [5:0]        dt;
  logic [1:0]        vc;
  logic              is_accept;

  assign in_data   = bus.I_Byte_Data;
  assign in_vld    = bus.I_Byte_Valid;
  assign wc        = {in_data[7:0], wc_lo};
  assign dt        = di[5:0];
  assign vc        = di[7:6];
  assign is_accept = ({2'b00, dt} == DT_Accept);

  always_ff @(posedge I_CLK or negedge I_Rst_n) begin
    if (!I_Rst_n) begin
      state    <= ST_IDLE;
      di       <= '0;
      wc_lo    <= '0;
      word_cnt <= '0;
      fwd      <= 1'b0;
      err_done <= 1'b0;
      data_p1  <= '0;
      vld_p1   <= 1'b0;
      vsync    <= 1'b0;
      line_cnt <= '0;
      pkt_err  <= 1'b0;
    end else begin
      vld_p1  <= 1'b0;
      pkt_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_vld) begin
            di       <= in_data[7:0];
            wc_lo    <= in_data[15:8];
            err_done <= 1'b0;
            state    <= ST_HDR2;
          end
        end
        ST_HDR2: begin
          if (!in_vld) begin
            pkt_err <= 1'b1;
            state   <= ST_IDLE;
          end else if (vc != VC_Accept) begin
            state <= ST_WAIT_EOT;
          end else if (dt < 6'h10) begin
            state <= ST_WAIT_EOT;
            if ({2'b00, dt} == DT_FS) begin
              // A repeated FS is flagged but V_sync stays high without a glitch
              pkt_err  <= vsync;
              vsync    <= 1'b1;
              line_cnt <= '0;
            end else if ({2'b00, dt} == DT_FE) begin
              vsync <= 1'b0;
            end
          end else if (wc[0]) begin
            pkt_err <= 1'b1;
            state   <= ST_WAIT_EOT;
          end else begin
            fwd      <= is_accept;
            word_cnt <= wc[15:1];
            if (is_accept && (wc != 16'(Line_Bytes))) begin
              pkt_err  <= 1'b1;
              err_done <= 1'b1;
            end
            state <= (wc == 16'd0) ? ST_CRC : ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (!in_vld) begin
            pkt_err <= !err_done;
            state   <= ST_IDLE;
          end else begin
            if (fwd) begin
              data_p1 <= in_data;
              vld_p1  <= 1'b1;
            end
            word_cnt <= word_cnt - 15'd1;
            if (word_cnt == 15'd1) begin
              state <= ST_CRC;
              if (fwd) line_cnt <= sat_inc16(line_cnt);
            end
          end
        end
        ST_CRC: begin
          if (!in_vld) begin
            pkt_err <= !err_done;
            state   <= ST_IDLE;
          end else begin
            state <= ST_WAIT_EOT;
          end
        end
        ST_WAIT_EOT: begin
          if (!in_vld) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output stage (_p1): one cycle behind the captured payload word
  assign bus.O_Mipi_Unpacket_Data   = data_p1;
  assign bus.O_Mipi_Unpacket_Vaild  = vld_p1;
  assign bus.O_Mipi_Unpacket_V_sync = vsync;
  assign bus.O_Line_Cnt             = line_cnt;
  assign bus.O_Pkt_Err              = pkt_err;

`ifdef MIPI_CRC_CHECK_EN
  logic [15:0] crc_acc;
  logic        crc_err_p1;

  mipi_crc16_2byte u_crc (
    .clk   (I_CLK),
    .rst_n (I_Rst_n),
    .clr   (state == ST_HDR2),
    .en    ((state == ST_PAYLOAD) && in_vld && fwd),
    .din   (in_data),
    .crc   (crc_acc)
  );

  always_ff @(posedge I_CLK or negedge I_Rst_n) begin
    if (!I_Rst_n) begin
      crc_err_p1 <= 1'b0;
    end else begin
      crc_err_p1 <= (state == ST_CRC) && in_vld && fwd && (in_data != crc_acc);
    end
  end

  assign bus.O_Crc_Err = crc_err_p1;
`else
  assign bus.O_Crc_Err = 1'b0;
`endif

endmodule

// File: tb/tb_mipi_csi2_pkt_unpack.sv
// Randomized self-checking bench for mipi_csi2_pkt_unpack with a packet-level reference model.
module tb_mipi_csi2_pkt_unpack;
  import mipi_csi2_pkt_unpack_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;

  mipi_csi2_pkt_unpack_if bus();

  mipi_csi2_pkt_unpack dut (
    .I_CLK   (clk),
    .I_Rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge
  logic [15:0] out_q[$];
  int perr_n = 0, cerr_n = 0, vrise_n = 0, vsrise_n = 0, delay_bad = 0, cerr_cyc = 0;
  logic vld_d = 1'b0, vs_d = 1'b0, inv_d = 1'b0;
  logic [15:0] in_d = '0;
  always @(negedge clk) begin
    if (bus.O_Mipi_Unpacket_Vaild) begin
      out_q.push_back(bus.O_Mipi_Unpacket_Data);
      if (!inv_d || in_d !== bus.O_Mipi_Unpacket_Data) delay_bad <= delay_bad + 1;
      if (!vld_d) vrise_n <= vrise_n + 1;
    end
    if (bus.O_Mipi_Unpacket_V_sync && !vs_d) vsrise_n <= vsrise_n + 1;
    if (bus.O_Pkt_Err) perr_n <= perr_n + 1;
    if (bus.O_Crc_Err) begin
      cerr_n   <= cerr_n + 1;
      cerr_cyc <= cyc;
    end
    vld_d <= bus.O_Mipi_Unpacket_Vaild;
    vs_d  <= bus.O_Mipi_Unpacket_V_sync;
    in_d  <= bus.I_Byte_Data;
    inv_d <= bus.I_Byte_Valid;
  end

  // Reference model state
  logic        m_vsync = 1'b0;
  logic [15:0] m_line = '0;
  logic [15:0] exp_q[$];
  int exp_perr, exp_cerr;
  logic [15:0] pkt[$];
  int last_drive_cyc = 0;

  function automatic logic [15:0] tb_crc(input logic [15:0] w[$]);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    foreach (w[i]) begin
      for (int b = 0; b < 16; b++) begin
        fb = c[0] ^ w[i][b];
        c = c >> 1;
        if (fb) c = c ^ 16'h8408;
      end
    end
    return c;
  endfunction

  task automatic mk_short(input logic [7:0] di);
    pkt.delete();
    pkt.push_back({8'h00, di});
    pkt.push_back({8'($urandom), 8'h00});
  endtask

  task automatic mk_long(input logic [7:0] di, input logic [15:0] wc, input bit ramp, input int flip);
    logic [15:0] pl[$];
    logic [15:0] crc;
    logic [15:0] t;
    pkt.delete();
    for (int i = 0; i < int'(wc) / 2; i++) pl.push_back(ramp ? 16'(i) : 16'($urandom));
    crc = tb_crc(pl);
    if (flip >= 0) begin
      t = pl[flip / 16];
      t[flip % 16] = ~t[flip % 16];
      pl[flip / 16] = t;
    end
    pkt.push_back({wc[7:0], di});
    pkt.push_back({8'($urandom), wc[15:8]});
    foreach (pl[i]) pkt.push_back(pl[i]);
    pkt.push_back(crc);
  endtask

  // Packet-level behaviour derived from the protocol rules, not from the FSM
  task automatic model_pkt(input logic [15:0] w[$]);
    int n, nw, avail;
    logic [7:0] di;
    logic [15:0] wc;
    logic acc;
    logic [15:0] pl[$];
    exp_q.delete();
    exp_perr = 0;
    exp_cerr = 0;
    n = w.size();
    if (n == 0) return;
    if (n < 2) begin
      exp_perr = 1;
      return;
    end
    di = w[0][7:0];
    wc = {w[1][7:0], w[0][15:8]};
    if (di[7:6] != 2'd0) return;
    if (di[5:0] < 6'h10) begin
      if (di[5:0] == 6'h00) begin
        if (m_vsync) exp_perr = 1;
        m_vsync = 1'b1;
        m_line = 16'd0;
      end else if (di[5:0] == 6'h01) begin
        m_vsync = 1'b0;
      end
      return;
    end
    if (wc[0]) begin
      exp_perr = 1;
      return;
    end
    acc = (di[5:0] == 6'h1E);
    nw = int'(wc) / 2;
    avail = n - 2;
    if (acc && wc != 16'd3840) exp_perr = 1;
    if (avail < nw + 1) exp_perr = 1;
    for (int i = 0; i < nw && i < avail; i++) begin
      pl.push_back(w[2 + i]);
      if (acc) exp_q.push_back(w[2 + i]);
    end
    if (acc && nw > 0 && avail >= nw && m_line != 16'hFFFF) m_line = m_line + 16'd1;
`ifdef MIPI_CRC_CHECK_EN
    if (acc && avail >= nw + 1 && tb_crc(pl) != w[2 + nw]) exp_cerr = 1;
`endif
  endtask

  task automatic send(input logic [15:0] w[$], input int idle);
    foreach (w[i]) begin
      @(posedge clk);
      #1;
      bus.I_Byte_Data  = w[i];
      bus.I_Byte_Valid = 1'b1;
      last_drive_cyc   = cyc;
    end
    @(posedge clk);
    #1;
    bus.I_Byte_Valid = 1'b0;
    bus.I_Byte_Data  = 16'($urandom);
    repeat (idle) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int p0;
    bus.I_Byte_Data  = '0;
    bus.I_Byte_Valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (bus.O_Mipi_Unpacket_Data !== 16'h0) $display("FAIL rst_data: got %h, expected 0000", bus.O_Mipi_Unpacket_Data);
    n_fail += (bus.O_Mipi_Unpacket_Data !== 16'h0) ? 1 : 0;
    n_tests++; if (bus.O_Mipi_Unpacket_Vaild !== 1'b0) begin n_fail++; $display("FAIL rst_vaild: got %b, expected 0", bus.O_Mipi_Unpacket_Vaild); end
    n_tests++; if (bus.O_Mipi_Unpacket_V_sync !== 1'b0) begin n_fail++; $display("FAIL rst_vsync: got %b, expected 0", bus.O_Mipi_Unpacket_V_sync); end
    n_tests++; if (bus.O_Line_Cnt !== 16'h0) begin n_fail++; $display("FAIL rst_line: got %0d, expected 0", bus.O_Line_Cnt); end
    n_tests++; if (bus.O_Pkt_Err !== 1'b0 || bus.O_Crc_Err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b%b, expected 00", bus.O_Pkt_Err, bus.O_Crc_Err); end
    rst_n = 1'b1;
    // Reset in the middle of a line after FS
    mk_short(DT_FS);
    send(pkt, 2);
    mk_long(DT_YUV422_8, 16'd3840, 1'b1, -1);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      bus.I_Byte_Data  = pkt[i];
      bus.I_Byte_Valid = 1'b1;
    end
    p0 = perr_n;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.I_Byte_Valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    m_vsync = 1'b0;
    m_line = '0;
    n_tests++; if (perr_n - p0 !== 0) begin n_fail++; $display("FAIL midrst_perr: got %0d, expected 0", perr_n - p0); end
    n_tests++; if (bus.O_Mipi_Unpacket_V_sync !== 1'b0) begin n_fail++; $display("FAIL midrst_vsync: got %b, expected 0", bus.O_Mipi_Unpacket_V_sync); end
    n_tests++; if (bus.O_Mipi_Unpacket_Vaild !== 1'b0) begin n_fail++; $display("FAIL midrst_vaild: got %b, expected 0", bus.O_Mipi_Unpacket_Vaild); end
  endtask

  task automatic test_fs_fe();
    int p0;
    p0 = perr_n;
    @(posedge clk);
    #1;
    bus.I_Byte_Data = 16'h0000;
    bus.I_Byte_Valid = 1'b1;
    @(posedge clk);
    #1;
    bus.I_Byte_Data = 16'hA500;
    @(negedge clk);
    n_tests++; if (bus.O_Mipi_Unpacket_V_sync !== 1'b0) begin n_fail++; $display("FAIL fs_early: got %b, expected 0", bus.O_Mipi_Unpacket_V_sync); end
    @(negedge clk);
    n_tests++; if (bus.O_Mipi_Unpacket_V_sync !== 1'b1) begin n_fail++; $display("FAIL fs_rise: got %b, expected 1", bus.O_Mipi_Unpacket_V_sync); end
    @(posedge clk);
    #1;
    bus.I_Byte_Valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_vsync = 1'b1;
    m_line = '0;
    mk_short(DT_FE);
    model_pkt(pkt);
    send(pkt, 3);
    n_tests++; if (bus.O_Mipi_Unpacket_V_sync !== 1'b0) begin n_fail++; $display("FAIL fe_fall: got %b, expected 0", bus.O_Mipi_Unpacket_V_sync); end
    n_tests++; if (perr_n - p0 !== 0) begin n_fail++; $display("FAIL fsfe_perr: got %0d, expected 0", perr_n - p0); end
  endtask

  task automatic test_line();
    int p0, c0, v0, d0, bad;
    mk_short(DT_FS);
    model_pkt(pkt);
    send(pkt, 2);
    mk_long(DT_YUV422_8, 16'd3840, 1'b1, -1);
    model_pkt(pkt);
    out_q.delete();
    p0 = perr_n; c0 = cerr_n; v0 = vrise_n; d0 = delay_bad;
    send(pkt, 3);
    bad = -1;
    foreach (exp_q[i]) if (bad < 0 && (i >= out_q.size() || out_q[i] !== exp_q[i])) bad = i;
    n_tests++; if (out_q.size() !== 1920) begin n_fail++; $display("FAIL line_len: got %0d, expected 1920", out_q.size()); end
    n_tests++; if (bad !== -1) begin n_fail++; $display("FAIL line_data: first bad word %0d, expected none", bad); end
    n_tests++; if (vrise_n - v0 !== 1) begin n_fail++; $display("FAIL line_contig: got %0d rises, expected 1", vrise_n - v0); end
    n_tests++; if (delay_bad - d0 !== 0) begin n_fail++; $display("FAIL line_delay: got %0d late words, expected 0", delay_bad - d0); end
    n_tests++; if (bus.O_Line_Cnt !== 16'd1) begin n_fail++; $display("FAIL line_cnt: got %0d, expected 1", bus.O_Line_Cnt); end
    n_tests++; if (perr_n - p0 !== 0 || cerr_n - c0 !== 0) begin n_fail++; $display("FAIL line_err: got perr %0d crc %0d, expected 0 0", perr_n - p0, cerr_n - c0); end
  endtask

  task automatic test_crc_err();
    int c0, p0;
    mk_long(DT_YUV422_8, 16'd3840, 1'b1, 77);
    model_pkt(pkt);
    out_q.delete();
    c0 = cerr_n; p0 = perr_n;
    send(pkt, 3);
    n_tests++; if (cerr_n - c0 !== exp_cerr) begin n_fail++; $display("FAIL crc_err: got %0d, expected %0d", cerr_n - c0, exp_cerr); end
    n_tests++; if (out_q.size() !== 1920) begin n_fail++; $display("FAIL crc_fwd: got %0d, expected 1920", out_q.size()); end
    n_tests++; if (perr_n - p0 !== 0) begin n_fail++; $display("FAIL crc_perr: got %0d, expected 0", perr_n - p0); end
`ifdef MIPI_CRC_CHECK_EN
    n_tests++; if (cerr_cyc - last_drive_cyc !== 1) begin n_fail++; $display("FAIL crc_timing: got %0d, expected 1", cerr_cyc - last_drive_cyc); end
`endif
  endtask

  task automatic test_truncate();
    int p0, bad;
    mk_long(DT_YUV422_8, 16'd3840, 1'b1, -1);
    while (pkt.size() > 102) void'(pkt.pop_back());
    model_pkt(pkt);
    out_q.delete();
    p0 = perr_n;
    send(pkt, 3);
    n_tests++; if (perr_n - p0 !== 1) begin n_fail++; $display("FAIL trunc_perr: got %0d, expected 1", perr_n - p0); end
    n_tests++; if (out_q.size() !== 100) begin n_fail++; $display("FAIL trunc_len: got %0d, expected 100", out_q.size()); end
    n_tests++; if (bus.O_Mipi_Unpacket_Vaild !== 1'b0) begin n_fail++; $display("FAIL trunc_vaild: got %b, expected 0", bus.O_Mipi_Unpacket_Vaild); end
    mk_long(DT_YUV422_8, 16'd3840, 1'b0, -1);
    model_pkt(pkt);
    out_q.delete();
    p0 = perr_n;
    send(pkt, 3);
    bad = -1;
    foreach (exp_q[i]) if (bad < 0 && (i >= out_q.size() || out_q[i] !== exp_q[i])) bad = i;
    n_tests++; if (perr_n - p0 !== 0) begin n_fail++; $display("FAIL after_trunc_perr: got %0d, expected 0", perr_n - p0); end
    n_tests++; if (out_q.size() !== 1920 || bad !== -1) begin n_fail++; $display("FAIL after_trunc_data: got %0d words bad %0d, expected 1920 none", out_q.size(), bad); end
    n_tests++; if (bus.O_Line_Cnt !== m_line) begin n_fail++; $display("FAIL after_trunc_line: got %0d, expected %0d", bus.O_Line_Cnt, m_line); end
  endtask

  task automatic test_odd_vc_dt();
    int p0, v0;
    int exp_e[3] = '{1, 0, 0};
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: mk_long(DT_YUV422_8, 16'd5, 1'b0, -1);
        1: mk_long(8'h40 | DT_YUV422_8, 16'd8, 1'b0, -1);
        default: mk_long(DT_RAW10, 16'd8, 1'b0, -1);
      endcase
      model_pkt(pkt);
      out_q.delete();
      p0 = perr_n; v0 = vrise_n;
      send(pkt, 3);
      n_tests++; if (perr_n - p0 !== exp_e[k]) begin n_fail++; $display("FAIL odd_vc_dt_perr[%0d]: got %0d, expected %0d", k, perr_n - p0, exp_e[k]); end
      n_tests++; if (out_q.size() !== 0 || vrise_n - v0 !== 0) begin n_fail++; $display("FAIL odd_vc_dt_vaild[%0d]: got %0d words, expected 0", k, out_q.size()); end
    end
  endtask

  task automatic test_frame();
    int v0, s0;
    mk_short(DT_FE);
    model_pkt(pkt);
    send(pkt, 2);
    v0 = vrise_n; s0 = vsrise_n;
    mk_short(DT_FS);
    model_pkt(pkt);
    send(pkt, 1);
    for (int l = 0; l < 1080; l++) begin
      mk_long(DT_YUV422_8, 16'd8, 1'b0, -1);
      model_pkt(pkt);
      send(pkt, 1);
      out_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (bus.O_Line_Cnt !== 16'd1080) begin n_fail++; $display("FAIL frame_lines: got %0d, expected 1080", bus.O_Line_Cnt); end
    n_tests++; if (vrise_n - v0 !== 1080) begin n_fail++; $display("FAIL frame_vaild_rises: got %0d, expected 1080", vrise_n - v0); end
    n_tests++; if (vsrise_n - s0 !== 1) begin n_fail++; $display("FAIL frame_vsync_rises: got %0d, expected 1", vsrise_n - s0); end
    mk_short(DT_FE);
    model_pkt(pkt);
    send(pkt, 3);
    n_tests++; if (bus.O_Mipi_Unpacket_V_sync !== 1'b0 || bus.O_Line_Cnt !== 16'd1080) begin n_fail++; $display("FAIL frame_end: got vsync %b line %0d, expected 0 1080", bus.O_Mipi_Unpacket_V_sync, bus.O_Line_Cnt); end
  endtask

  task automatic test_random();
    int kind, p0, c0, bad, cut, fl;
    logic [15:0] wc;
    for (int k = 0; k < 80; k++) begin
      kind = $urandom_range(0, 8);
      wc = 16'(2 * $urandom_range(0, 12));
      fl = ($urandom_range(0, 2) == 0 && wc > 0) ? int'($urandom_range(0, int'(wc) * 8 - 1)) : -1;
      case (kind)
        0: mk_short(DT_FS);
        1: mk_short(DT_FE);
        2: mk_short(($urandom_range(0, 1) == 1) ? DT_LS : DT_LE);
        3: mk_long(DT_YUV422_8, wc, 1'b0, fl);
        4: mk_long(DT_YUV422_8, wc | 16'd1, 1'b0, -1);
        5: mk_long(8'h40 | DT_YUV422_8, wc, 1'b0, -1);
        6: mk_long(($urandom_range(0, 1) == 1) ? DT_RAW10 : DT_RGB565, wc, 1'b0, -1);
        7: begin
          mk_long(DT_YUV422_8, wc, 1'b0, -1);
          cut = $urandom_range(1, pkt.size() - 1);
          while (pkt.size() > cut) void'(pkt.pop_back());
        end
        default: mk_short(8'h80 | DT_FS);
      endcase
      model_pkt(pkt);
      out_q.delete();
      p0 = perr_n; c0 = cerr_n;
      send(pkt, 3);
      bad = -1;
      foreach (exp_q[i]) if (bad < 0 && (i >= out_q.size() || out_q[i] !== exp_q[i])) bad = i;
      n_tests++; if (out_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rnd%0d_len kind %0d: got %0d, expected %0d", k, kind, out_q.size(), exp_q.size()); end
      n_tests++; if (bad !== -1) begin n_fail++; $display("FAIL rnd%0d_data kind %0d: first bad word %0d, expected none", k, kind, bad); end
      n_tests++; if (perr_n - p0 !== exp_perr) begin n_fail++; $display("FAIL rnd%0d_perr kind %0d: got %0d, expected %0d", k, kind, perr_n - p0, exp_perr); end
      n_tests++; if (cerr_n - c0 !== exp_cerr) begin n_fail++; $display("FAIL rnd%0d_crc kind %0d: got %0d, expected %0d", k, kind, cerr_n - c0, exp_cerr); end
      n_tests++; if (bus.O_Mipi_Unpacket_V_sync !== m_vsync) begin n_fail++; $display("FAIL rnd%0d_vsync kind %0d: got %b, expected %b", k, kind, bus.O_Mipi_Unpacket_V_sync, m_vsync); end
      n_tests++; if (bus.O_Line_Cnt !== m_line) begin n_fail++; $display("FAIL rnd%0d_line kind %0d: got %0d, expected %0d", k, kind, bus.O_Line_Cnt, m_line); end
    end
  endtask

  initial begin
    test_reset();
    test_fs_fe();
    test_line();
    test_crc_err();
    test_truncate();
    test_odd_vc_dt();
    test_frame();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mipi_csi2_pkt_unpack.md
Name: mipi_csi2_pkt_unpack

Overview: Parses byte-aligned 2-lane CSI-2 HS bursts from the D-PHY byte/lane aligner into a 16-bit pixel stream with a frame-level V_sync. Sits directly upstream of the unpacked-stream pixel/line counting and checking logic and drives its data, valid and V_sync inputs. One packet per HS burst. Short FS/FE packets control V_sync. Long packets of the accepted data type become payload words.

Parameters:
Lane_Num, 2, lanes; only 2 supported (16-bit word per cycle)
Byte_w, 8, bits per lane byte
DT_Accept, 8'h1E, long-packet data type forwarded (YUV422 8-bit)
VC_Accept, 2'd0, virtual channel accepted (DI[7:6])
Line_Bytes, 3840, expected word count per line (1920 px x 2 B)

Ports:
I_CLK  in  1  byte clock
I_Rst_n  in  1  async active-low reset
I_Byte_Data  in  16  aligned lane data; [7:0]=lane0 = earlier byte, [15:8]=lane1 = later byte
I_Byte_Valid  in  1  high during HS burst payload (sync bytes stripped)
O_Mipi_Unpacket_Data  out  16  payload word, same byte order as input
O_Mipi_Unpacket_Vaild  out  1  payload word valid
O_Mipi_Unpacket_V_sync  out  1  high from FS to FE
O_Line_Cnt  out  16  accepted long packets since last FS
O_Pkt_Err  out  1  one-cycle pulse on protocol error
O_Crc_Err  out  1  one-cycle pulse on payload CRC mismatch

Behaviour:
- Reset: all outputs 0, FSM to IDLE, WC counter 0. Reset mid-packet abandons the packet and emits no error pulse.
- FSM states: IDLE, HDR2, PAYLOAD, CRC, WAIT_EOT.
- IDLE: first cycle with Valid=1 is header word 1. Latch DI=[7:0] and WC[7:0]=[15:8], then go to HDR2.
- HDR2: latch WC[15:8]=[7:0]. ECC byte [15:8] is ignored. Decode with DT=DI[5:0] and VC=DI[7:6]:
  - VC != VC_Accept: WAIT_EOT, silently.
  - DT 0x00 (FS): V_sync=1 next cycle and O_Line_Cnt=0. If V_sync is already 1, pulse Pkt_Err and keep V_sync high (no low glitch).
  - DT 0x01 (FE): V_sync=0 next cycle. Go to WAIT_EOT.
  - Other short DT (0x02-0x0F): ignored, WAIT_EOT.
  - Long packet, DT=DT_Accept, WC even, WC>0: PAYLOAD with counter=WC/2.
  - Long packet, WC=0: CRC.
  - WC odd: Pkt_Err pulse, WAIT_EOT.
  - Other long DT: consume and discard the WC/2 words plus CRC with no valid output.
- PAYLOAD: each input word is registered to Data with Vaild=1 exactly 1 cycle later. Decrement the counter; at the last word go to CRC. Line_Cnt increments on the last payload word (saturates at 16'hFFFF).
- WC != Line_Bytes: Pkt_Err pulse in the cycle after HDR2. Data is still forwarded.
- CRC: one word (CRC[7:0] in [7:0]), then WAIT_EOT.
- WAIT_EOT: discard until Valid=0, then IDLE. Valid=0 in IDLE/WAIT_EOT is normal.
- Valid falling in HDR2/PAYLOAD/CRC means a truncated packet: Pkt_Err pulse, Vaild low, return to IDLE. V_sync is unchanged.
- Vaild is never high outside PAYLOAD+1, so downstream sees one valid rising edge per line.
- Simultaneous truncation and odd-WC cannot occur (distinct states). At most one Pkt_Err pulse per packet.

Optional Feature:
MIPI_CRC_CHECK_EN:
- Defined: CRC-16/CCITT (poly 0x1021 reflected, init 0xFFFF, LSB-first, per CSI-2) is computed over the forwarded payload bytes and compared with the CRC word. On mismatch, O_Crc_Err pulses 1 cycle after the CRC word. Data already forwarded is not recalled.
- Undefined: CRC word skipped, O_Crc_Err tied 0, no CRC logic.

Decomposition:
- Shared package holds:
  - Data-type constants: DT_FS 8'h00, DT_FE 8'h01, DT_LS 8'h02, DT_LE 8'h03, DT_YUV422_8 8'h1E, DT_RGB565 8'h22, DT_RAW10 8'h2B.
  - FSM state encoding.
  - CRC init/poly constants.
- One sub-module, mipi_crc16_2byte: combinational next-CRC for two bytes per cycle plus an accumulator register. Instantiated only under MIPI_CRC_CHECK_EN.

Test Plan:
- FS short packet (words 16'h0000, 16'hXX00, VC0) -> V_sync rises 1 cycle after word 2. FE -> V_sync falls; Pkt_Err=0.
- Long packet DI=0x1E, WC=3840, 1920 ramp words, correct CRC -> 1920 contiguous Vaild cycles; data = input delayed 1 cycle; Line_Cnt=1; Crc_Err=0.
- Same packet with one payload bit flipped (CRC_EN defined) -> Crc_Err pulse 1 cycle after CRC word. Without the macro -> Crc_Err stays 0.
- Full frame: FS, 1080 lines, FE -> Line_Cnt=1080; exactly one V_sync rising edge; 1080 Vaild rising edges.
- Valid dropped after 100 payload words -> Pkt_Err pulse; Vaild low; next packet parses correctly.
- Odd WC=5, VC=1 packet, DT=0x2B packet -> Pkt_Err only for the WC=5 case; no Vaild for any of them.
